fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling FIFO between the fetch stage (PC/IM) and the decode stage. It holds fetched instruction words with their PC and fetch-exception code, so that a decode stall does not immediately freeze the PC. It also absorbs one-cycle fetch bubbles. The whole queue is discarded on a control-flow redirect (branch/jump resolution, exception entry, ERET).

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, 2..16.
- AW, 2: pointer width, log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all entries and any same-cycle push.
- in_valid  in  1  fetch stage presents a word this cycle.
- in_code  in  32  instruction word.
- in_pc  in  32  its PC.
- in_exc  in  5  fetch exception code, bits [6:2]; 0 means none.
- in_ready  out  1  queue accepts a push this cycle.
- out_valid  out  1  head entry valid.
- out_code  out  32  head instruction; 0 when !out_valid.
- out_pc  out  32  head PC; 0 when !out_valid.
- out_exc  out  5  head exception code; 0 when !out_valid.
- out_ready  in  1  decode consumes the head this cycle (= !stall_ID).
- count  out  AW+1  occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer with write pointer wp[AW-1:0], read pointer rp[AW-1:0] and occupancy cnt[AW:0]. Pointers wrap modulo DEPTH.
- Handshakes:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- in_ready = (cnt != DEPTH). It is combinational from registered state only and does not depend on out_ready. A full queue therefore refuses a push even while popping.
- out_valid = (cnt != 0). Payload outputs come from mem[rp], masked to 0 when empty (the NOP bubble).
- Per cycle:
  - push only: write mem[wp], wp+1, cnt+1.
  - pop only: rp+1, cnt-1.
  - both: write and advance both pointers, cnt unchanged.
- Priority: reset > flush > push/pop.
  - flush sets wp=rp=cnt=0 and never writes mem.
  - Entries are not cleared on flush; the output mask covers stale data.
- An exception-tagged entry (in_exc != 0) is queued like any other; the queue does not interpret exception codes.
- Order is strict FIFO: no reordering and no duplication.
- A push while in_ready=0 is dropped. The fetch stage must hold its PC while in_ready=0, i.e. stallPC = !in_ready.

## Timing
- Reset: cnt=0, wp=0, rp=0, so out_valid=0, out_code=0, out_pc=0, out_exc=0, in_ready=1, count=0.
- Without bypass, latency is 1 cycle: a word pushed at edge N is visible at the outputs after edge N.
- Throughput: 1 push and 1 pop per cycle in steady state.
- Full (cnt==DEPTH): in_ready=0. After a pop at edge N, in_ready=1 in cycle N+1.
- Empty (cnt==0): out_valid=0 and outputs are zero. A pop request is ignored.
- Simultaneous flush+push: the push is dropped and cnt=0 after the edge. Simultaneous flush+pop: the queue is emptied and the pop is treated as consumed.
- count is registered state (cnt) and is valid every cycle.

## Configuration
- FETCH_QUEUE_BYPASS_EN
  - Defined: when cnt==0, out_valid=in_valid and out_* pass in_* combinationally. If out_ready & in_valid & !flush in that cycle, the word is consumed without being stored (cnt stays 0, pointers unchanged). Fetch-to-decode latency is then 0 cycles through the queue. The path in_*→out_* is combinational.
  - Undefined: no in→out combinational path. An empty queue outputs zeros, and the minimum latency is 1 cycle.

## Test plan
- Reset mid-stream:
  - Stimulus: push 3 words, assert reset for one cycle.
  - Required: count=0, out_valid=0, out_pc=0, in_ready=1 on the next cycle.
- Fill/overflow, DEPTH=4:
  - Stimulus: out_ready=0, push PCs 0x3000, 0x3004, 0x3008, 0x300C, then offer 0x3010.
  - Required: in_ready=0 after the 4th push, count=4, 0x3010 not stored.
  - Then pop 4 times: out_pc sequence 0x3000..0x300C, in order.
- Wrap-around:
  - Stimulus: 10 pushes with concurrent pops (out_ready=1) after the first.
  - Required: count stays 1, PCs emerge in order across the pointer wrap.
- Flush with push:
  - Stimulus: 2 entries queued; in one cycle assert flush with in_valid=1, in_pc=0x4180.
  - Required: count=0, out_valid=0 next cycle; the 0x4180 word is not present later.
- Exception passthrough:
  - Stimulus: push in_exc=5'd4 (AdEL), in_pc=0x2FFC, in_code=0.
  - Required: the head shows out_exc=4, out_pc=0x2FFC, out_code=0.
- Bypass (macro on):
  - Stimulus: empty queue, in_valid=1, out_ready=1, in_code=0x24010001.
  - Required: out_code=0x24010001 in the same cycle, count stays 0.
  - With the macro off: out_valid=0 that cycle and the word appears next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between the fetch stage and the decode stage.
// Latency: 1 cycle push-to-head. With FETCH_QUEUE_BYPASS_EN an empty queue
//   passes the fetch word straight through combinationally (0 cycles).
// Backpressure: in_ready drops only when the queue is full. It is computed
//   from registered occupancy alone, so a full queue refuses a push even in a
//   cycle that pops.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue passthrough).
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   flush             discard every entry and any same-cycle push (redirect)
//   in_valid/in_ready push handshake from fetch; in_code/in_pc/in_exc payload
//   out_valid         head valid; out_code/out_pc/out_exc are 0 when invalid
//   out_ready         decode consumes the head (= !stall_ID)
//   count             registered occupancy, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_code,
  input  logic [31:0]   in_pc,
  input  logic [4:0]    in_exc,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_code,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_exc,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Storage. No reset: stale entries are harmless because the output mask
  // hides anything outside the rp..wp window.
  logic [31:0] mem_code [DEPTH];
  logic [31:0] mem_pc   [DEPTH];
  logic [4:0]  mem_exc  [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  logic empty;
  logic full;
  logic push;
  logic q_pop;
  logic wr_en;
  logic bypass_take;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

  assign in_ready = !full;
  assign count    = cnt;

  assign push  = in_valid & in_ready & !flush;
  // Only a stored entry is popped; a bypassed word never touches cnt/rp.
  assign q_pop = !empty & out_ready & !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue and decode ready: hand the word over directly, no storage.
  assign bypass_take = empty & in_valid & out_ready & !flush;
`else
  assign bypass_take = 1'b0;
`endif

  assign wr_en = push & !bypass_take;

  // Pointer / occupancy state. Reset outranks flush, flush outranks traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        wp <= wp + PTR_ONE;
      end
      if (q_pop) begin
        rp <= rp + PTR_ONE;
      end
      case ({wr_en, q_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload write. wr_en already excludes flush; reset also blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_code[wp] <= in_code;
      mem_pc[wp]   <= in_pc;
      mem_exc[wp]  <= in_exc;
    end
  end

  // Head outputs, masked to a zero (NOP) bubble when nothing is valid.
  always_comb begin
    out_valid = 1'b0;
    out_code  = '0;
    out_pc    = '0;
    out_exc   = '0;
    if (!empty) begin
      out_valid = 1'b1;
      out_code  = mem_code[rp];
      out_pc    = mem_pc[rp];
      out_exc   = mem_exc[rp];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (in_valid) begin
      out_valid = 1'b1;
      out_code  = in_code;
      out_pc    = in_pc;
      out_exc   = in_exc;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_code;
  logic [31:0] in_pc;
  logic [4:0]  in_exc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_code;
  logic [31:0] out_pc;
  logic [4:0]  out_exc;
  logic        out_ready;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_pc     (in_pc),
    .in_exc    (in_exc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_pc    (out_pc),
    .out_exc   (out_exc),
    .out_ready (out_ready),
    .count     (count)
  );

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic [4:0]  exc;
  } ent_t;

  ent_t sb[$];          // expected queue contents, head at index 0
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge against
  // the scoreboard, then advance the scoreboard the way the queue should.
  task automatic cyc(input logic v, input logic [31:0] code, input logic [31:0] pc,
                     input logic [4:0] exc, input logic rdy, input logic fl);
    int          n;
    logic        ev;
    logic [31:0] ec;
    logic [31:0] ep;
    logic [4:0]  ee;
    ent_t        e;
    in_valid  = v;
    in_code   = code;
    in_pc     = pc;
    in_exc    = exc;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    n  = sb.size();
    ev = 1'b0; ec = '0; ep = '0; ee = '0;
    if (n > 0) begin
      ev = 1'b1; ec = sb[0].code; ep = sb[0].pc; ee = sb[0].exc;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (v) begin
      ev = 1'b1; ec = code; ep = pc; ee = exc;
    end
`endif
    chk("count",     32'(count),     32'(n));
    chk("in_ready",  32'(in_ready),  32'(n != 4));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_pc",    out_pc,         ep);
    chk("out_code",  out_code,       ec);
    chk("out_exc",   32'(out_exc),   32'(ee));
    if (fl) begin
      sb.delete();
    end else begin
      e.code = code; e.pc = pc; e.exc = exc;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (n == 0 && v && rdy) begin
        // consumed straight through, nothing stored
      end else
`endif
      begin
        if (rdy && n > 0) void'(sb.pop_front());
        if (v && n != 4) sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, rdy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_code = '0; in_pc = '0;
    in_exc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    idle(1'b0);

    // Exception-tagged entry passes through unchanged
    cyc(1'b1, 32'h0, 32'h0000_2FFC, 5'd4, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill to DEPTH, offer a fifth word, then drain in order
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'hA000_0000 + 32'(i), 32'h3000 + 32'(4*i), 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA000_0004, 32'h3010, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Wrap-around with concurrent push and pop
    cyc(1'b1, 32'hB000_0000, 32'h5000, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++)
      cyc(1'b1, 32'hB000_0000 + 32'(i), 32'h5000 + 32'(4*i), 5'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Flush with a same-cycle push: the push must vanish
    cyc(1'b1, 32'hC000_0001, 32'h4100, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC000_0002, 32'h4104, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC000_0003, 32'h4180, 5'd0, 1'b0, 1'b1);
    idle(1'b0);
    cyc(1'b1, 32'hC000_0004, 32'h6000, 5'd0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Flush with a same-cycle pop
    cyc(1'b1, 32'hC000_0005, 32'h6100, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'hC000_0006, 32'h6104, 5'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    idle(1'b1);

    // Full queue refuses a push even while popping
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'hD000_0000 + 32'(i), 32'h8000 + 32'(4*i), 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'hD000_0004, 32'h8010, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 32'hD000_0005, 32'h8014, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b0);

    // Empty-queue fetch with decode ready (bypass or 1-cycle latency)
    cyc(1'b1, 32'h2401_0001, 32'h7000, 5'd0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'hE000_0000 + 32'(i), 32'h9000 + 32'(4*i), 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    idle(1'b0);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
